// File: rtl/main_memory_responder_if.sv
// rtl/main_memory_responder_if.sv - cache line-fill/writeback bus between data cache and memory
interface main_memory_responder_if #(
  parameter int LINE_WORDS = 4
);
  logic                       mem_req;
  logic                       mem_we;
  logic [31:0]                mem_addr;
  logic [32*LINE_WORDS-1:0]   mem_wline;
  logic [32*LINE_WORDS-1:0]   mem_rline;
  logic                       mem_ack;
  logic                       mem_busy;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wline,
    input  mem_rline, mem_ack, mem_busy
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wline,
    output mem_rline, mem_ack, mem_busy
  );
endinterface

// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - main-memory model servicing one cache line request at a time
// IDLE captures a request, WAIT burns LATENCY cycles then accesses the array, ACK pulses once.
module main_memory_responder #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 1024,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  main_memory_responder_if.slave mem
);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LINE_W  = 32 * LINE_WORDS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [AW-1:0]       base_q, base_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rline_q, rline_d;
  logic                access;
  logic [AW-1:0]       word_idx;
  logic                addr_unused;

  // Backing store is not touched by reset; it starts out zeroed.
  logic [31:0]         array_q [DEPTH] = '{default: '0};

  assign word_idx    = mem.mem_addr[AW+1:2];
  assign addr_unused = ^{mem.mem_addr[31:AW+2], mem.mem_addr[1:0]};
  assign access      = (state_q == S_WAIT) && mem.mem_req && (cnt_q == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    base_d  = base_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      S_IDLE: begin
        if (mem.mem_req) begin
          state_d = S_WAIT;
          cnt_d   = CW'(LATENCY - 1);
          we_d    = mem.mem_we;
          base_d  = word_idx & ~AW'(LINE_WORDS - 1);
          wline_d = mem.mem_wline;
        end
      end
      S_WAIT: begin
        if (!mem.mem_req) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_ACK;
          if (!we_q) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
              rline_d[k*32 +: 32] = array_q[base_q + AW'(k)];
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Line base is line-aligned, so adding k never carries out of the line and wraps mod DEPTH.
  always_ff @(posedge clk) begin
    if (access && we_q) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        array_q[base_q + AW'(k)] <= wline_q[k*32 +: 32];
      end
    end
  end

  always_comb begin
    mem.mem_ack   = (state_q == S_ACK);
    mem.mem_busy  = (state_q != S_IDLE);
    mem.mem_rline = rline_q;
  end
endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - directed self-checking bench for main_memory_responder
module tb_main_memory_responder;
  localparam int LINE_WORDS = 4;
  localparam int DEPTH      = 1024;
  localparam int LATENCY    = 4;

  localparam logic [127:0] LINE_A = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  localparam logic [127:0] LINE_X1 = {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000};
  localparam logic [127:0] LINE_X2 = {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000};
  localparam logic [127:0] LINE_Y  = {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  main_memory_responder_if #(.LINE_WORDS(LINE_WORDS)) bus ();

  main_memory_responder #(
    .LINE_WORDS(LINE_WORDS),
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mem  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [127:0] wline);
    int n;
    bus.mem_req   = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wline = wline;
    tick();
    n = 1;
    while (bus.mem_ack !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_ack"}, 128'(bus.mem_ack), 128'(1));
    chk({tag, "_lat"}, 128'(n), 128'(LATENCY + 1));
    bus.mem_req = 1'b0;
    tick();
    chk({tag, "_idle"}, 128'({bus.mem_ack, bus.mem_busy}), 128'(0));
  endtask

  initial begin
    int ack_n;
    int first_ack;
    int second_ack;
    int consec;
    logic prev_ack;

    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wline = '0;
    tick();
    tick();
    chk("rst_ack",   128'(bus.mem_ack),  128'(0));
    chk("rst_busy",  128'(bus.mem_busy), 128'(0));
    chk("rst_rline", bus.mem_rline,      128'(0));

    // Test 1: refill 0x40 with the request first seen at edge 1
    reset = 1'b1;
    bus.mem_req  = 1'b1;
    bus.mem_addr = 32'h0000_0040;
    for (int e = 1; e <= 4; e++) begin
      tick();
      chk($sformatf("t1_e%0d_ack", e),  128'(bus.mem_ack),  128'(0));
      chk($sformatf("t1_e%0d_busy", e), 128'(bus.mem_busy), 128'(1));
    end
    tick();
    chk("t1_e5_ack",   128'(bus.mem_ack),  128'(1));
    chk("t1_e5_busy",  128'(bus.mem_busy), 128'(1));
    chk("t1_e5_rline", bus.mem_rline,      128'(0));
    bus.mem_req = 1'b0;
    tick();
    chk("t1_e6_ack",  128'(bus.mem_ack),  128'(0));
    chk("t1_e6_busy", 128'(bus.mem_busy), 128'(0));

    // Test 2: writeback then refill with ignored low address bits
    do_req("t2_wr", 1'b1, 32'h0000_0040, LINE_A);
    chk("t2_rline_kept", bus.mem_rline, 128'(0));
    do_req("t2_rd", 1'b0, 32'h0000_004C, '0);
    chk("t2_w0", 128'(bus.mem_rline[31:0]),   128'(32'hAAAA_0000));
    chk("t2_w3", 128'(bus.mem_rline[127:96]), 128'(32'hDDDD_0003));
    chk("t2_line", bus.mem_rline, LINE_A);

    // Test 3: wrap-around beyond DEPTH
    do_req("t3_rd", 1'b0, 32'h0000_0040 + DEPTH * 4, '0);
    chk("t3_line", bus.mem_rline, LINE_A);

    // Test 4: aborted writeback leaves old data
    do_req("t4_wr1", 1'b1, 32'h0000_0080, LINE_X1);
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_0080;
    bus.mem_wline = LINE_X2;
    tick();
    tick();
    tick();
    chk("t4_wait_ack", 128'(bus.mem_ack), 128'(0));
    bus.mem_req = 1'b0;
    tick();
    chk("t4_abort_busy", 128'(bus.mem_busy), 128'(0));
    chk("t4_abort_ack",  128'(bus.mem_ack),  128'(0));
    chk("t4_rline_kept", bus.mem_rline,      LINE_A);
    tick();
    chk("t4_still_ack", 128'(bus.mem_ack), 128'(0));
    do_req("t4_rd", 1'b0, 32'h0000_0080, '0);
    chk("t4_line", bus.mem_rline, LINE_X1);

    // Test 5: asynchronous reset during a writeback WAIT
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_addr  = 32'h0000_00C0;
    bus.mem_wline = LINE_Y;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("t5_ack",   128'(bus.mem_ack),  128'(0));
    chk("t5_busy",  128'(bus.mem_busy), 128'(0));
    chk("t5_rline", bus.mem_rline,      128'(0));
    bus.mem_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    do_req("t5_rd", 1'b0, 32'h0000_00C0, '0);
    chk("t5_line", bus.mem_rline, 128'(0));
    do_req("t5_rd2", 1'b0, 32'h0000_0080, '0);
    chk("t5_line2", bus.mem_rline, LINE_X1);

    // Test 6: request held high across ACK
    ack_n = 0;
    first_ack = -1;
    second_ack = -1;
    consec = 0;
    prev_ack = 1'b0;
    bus.mem_req  = 1'b1;
    bus.mem_we   = 1'b0;
    bus.mem_addr = 32'h0000_0040;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (bus.mem_ack === 1'b1) begin
        ack_n++;
        if (first_ack < 0) first_ack = e;
        else if (second_ack < 0) second_ack = e;
        if (prev_ack === 1'b1) consec++;
      end
      prev_ack = bus.mem_ack;
      if (e == 11) bus.mem_req = 1'b0;
    end
    chk("t6_count",  128'(ack_n),                  128'(2));
    chk("t6_first",  128'(first_ack),              128'(LATENCY + 1));
    chk("t6_spacing", 128'(second_ack - first_ack), 128'(LATENCY + 2));
    chk("t6_consec", 128'(consec),                 128'(0));
    chk("t6_line",   bus.mem_rline,                LINE_A);
    chk("t6_idle",   128'(bus.mem_busy),           128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
